bound_flasher_param: RTL

Parametrised LED bound flasher: drives a thermometer-coded LED bar through a programmable sequence of alternating up/down phases, each ending at a per-phase target count. A `flick` input starts the sequence from idle and can kick the bar back into the preceding up phase at configured kick points. Step rate is set by an integrated prescaler. Sits at the top of the LED display path in place of the fixed 16-LED, six-phase flasher.

---
 rtl/bound_flasher_pkg.sv | 30 +++
 rtl/bf_step_timer.sv | 38 +++
 rtl/bound_flasher_param.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/bound_flasher_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bound_flasher_pkg: shared types, default sequence, therm decode    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package bound_flasher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } bf_state_e;

  localparam int BF_MAX_LEDS = 64;

  // Phase i target lives at [i*5 +: 5]; phase 0 in the low bits.
  localparam logic [29:0] BF_DEFAULT_TARGETS   = {5'd0, 5'd6, 5'd0, 5'd11, 5'd6, 5'd16};
  localparam logic [16:0] BF_DEFAULT_KICK_MASK = 17'h00041;

  function automatic logic [BF_MAX_LEDS-1:0] bf_therm(input logic [7:0] count);
    logic [BF_MAX_LEDS-1:0] v;
    v = '0;
    for (int i = 0; i < BF_MAX_LEDS; i++) begin
      v[i] = (8'(i) < count);
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bf_step_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bf_step_timer: step prescaler, one step pulse per STEP_DIV clocks  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module bf_step_timer #(
  parameter int STEP_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic step
);

  generate
    if (STEP_DIV <= 1) begin : g_div1
      logic w_unused;
      assign w_unused = ^{clk, reset, clr};
      assign step     = 1'b1;
    end else begin : g_divn
      localparam int TW = $clog2(STEP_DIV);
      localparam logic [TW-1:0] C_LAST = TW'(STEP_DIV - 1);
      logic [TW-1:0] r_tick;

      always_ff @(posedge clk) begin
        if (reset || clr || (r_tick == C_LAST)) begin
          r_tick <= '0;
        end else begin
          r_tick <= r_tick + TW'(1);
        end
      end

      assign step = (r_tick == C_LAST);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/bound_flasher_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bound_flasher_param: up/down LED bar sequencer with flick kickback |
// | Kickback built only when BOUND_FLASHER_KICKBACK_EN is defined.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module bound_flasher_param
  import bound_flasher_pkg::*;
#(
  parameter int LED_W    = 16,
  parameter int PHASES   = 6,
  parameter logic [PHASES*$clog2(LED_W+1)-1:0] TARGETS   = BF_DEFAULT_TARGETS,
  parameter logic [LED_W:0]                    KICK_MASK = BF_DEFAULT_KICK_MASK,
  parameter int STEP_DIV = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flick,
  output logic [LED_W-1:0]            led,
  output logic [$clog2(PHASES)-1:0]   phase,
  output logic                        busy
);

  localparam int CW = $clog2(LED_W + 1);
  localparam int PW = $clog2(PHASES);

  bf_state_e       r_st;
  logic [CW-1:0]   r_count;
  bf_state_e       w_st_nxt;
  logic [PW-1:0]   w_phase_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic [CW-1:0]   w_tgt [PHASES];
  logic [CW-1:0]   w_target;
  logic            w_start;
  logic            w_kick;
  logic            w_step;
  logic            w_last;

  generate
    if ((PHASES < 2) || (PHASES % 2 != 0)) begin : g_bad_phases
      $error("bound_flasher_param: PHASES must be even and >= 2");
    end
    if ((STEP_DIV < 1) || (LED_W > BF_MAX_LEDS)) begin : g_bad_sizes
      $error("bound_flasher_param: STEP_DIV must be >= 1 and LED_W <= 64");
    end
    // Up targets must climb above the preceding down target, down targets fall below the preceding up.
    for (genvar i = 0; i < PHASES; i++) begin : g_tgt
      localparam int T  = int'(TARGETS[i*CW +: CW]);
      localparam int PI = (i == 0) ? 0 : i - 1;
      localparam int PT = (i == 0) ? 0 : int'(TARGETS[PI*CW +: CW]);
      assign w_tgt[i] = TARGETS[i*CW +: CW];
      if (T > LED_W) begin : g_bad_range
        $error("bound_flasher_param: target exceeds LED_W");
      end
      if ((i % 2 == 0) && (T <= PT)) begin : g_bad_up
        $error("bound_flasher_param: up target not above previous down target");
      end
      if ((i % 2 == 1) && (T >= PT)) begin : g_bad_down
        $error("bound_flasher_param: down target not below previous up target");
      end
    end
  endgenerate

  assign w_target = w_tgt[phase];
  assign w_last   = (phase == PW'(PHASES - 1));

`ifdef BOUND_FLASHER_KICKBACK_EN
  assign w_kick = (r_st == DOWN) && flick && KICK_MASK[r_count] && !w_last;
`else
  logic w_unused_kick;
  assign w_unused_kick = ^KICK_MASK;
  assign w_kick        = 1'b0;
`endif

  bf_step_timer #(
    .STEP_DIV (STEP_DIV)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (w_start | w_kick),
    .step  (w_step)
  );

  always_comb begin
    w_st_nxt    = r_st;
    w_phase_nxt = phase;
    w_count_nxt = r_count;
    w_start     = 1'b0;
    case (r_st)
      IDLE: begin
        if (flick) begin
          w_start     = 1'b1;
          w_st_nxt    = UP;
          w_phase_nxt = '0;
          w_count_nxt = '0;
        end
      end
      UP: begin
        if (w_step) begin
          if (r_count != w_target) begin
            w_count_nxt = r_count + CW'(1);
          end else begin
            w_st_nxt    = DOWN;
            w_phase_nxt = phase + PW'(1);
            w_count_nxt = r_count - CW'(1);
          end
        end
      end
      DOWN: begin
        // A kick wins over a coincident step and freezes the count for that clock.
        if (w_kick) begin
          w_st_nxt    = UP;
          w_phase_nxt = phase - PW'(1);
        end else if (w_step) begin
          if (r_count != w_target) begin
            w_count_nxt = r_count - CW'(1);
          end else if (w_last) begin
            w_st_nxt    = IDLE;
            w_phase_nxt = '0;
            w_count_nxt = '0;
          end else begin
            w_st_nxt    = UP;
            w_phase_nxt = phase + PW'(1);
            w_count_nxt = r_count + CW'(1);
          end
        end
      end
      default: begin
        w_st_nxt    = IDLE;
        w_phase_nxt = '0;
        w_count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st    <= IDLE;
      r_count <= '0;
      phase   <= '0;
      led     <= '0;
      busy    <= 1'b0;
    end else begin
      r_st    <= w_st_nxt;
      r_count <= w_count_nxt;
      phase   <= w_phase_nxt;
      led     <= LED_W'(bf_therm(8'(w_count_nxt)));
      busy    <= (w_st_nxt != IDLE);
    end
  end

endmodule
`default_nettype wire
